// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: format codes, field widths,
// field bit positions inside the 32-bit word, encoder FSM states and a few
// common opcode/function values.
package instr_pkg;

    // fmt input encoding
    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_ILL = 2'd3;

    // field widths
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    // field LSB positions (op 31:26, rs 25:21, rt 20:16, rd 15:11,
    // shamt 10:6, funct 5:0, imm 15:0, target 25:0)
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    // opcode / function values
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: assembles a 32-bit instruction word from its fields
// according to fmt. Fields not used by the selected format are ignored.
// Ports:
//   fmt                      in  format select (R/I/J/illegal)
//   opcode..target           in  instruction fields
//   word                     out packed word (0 for illegal fmt)
//   legal                    out fmt is one of R/I/J
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm16,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            FMT_R: begin
                word[OP_LSB    +: OP_W]    = opcode;
                word[RS_LSB    +: REG_W]   = rs;
                word[RT_LSB    +: REG_W]   = rt;
                word[RD_LSB    +: REG_W]   = rd;
                word[SHAMT_LSB +: SHAMT_W] = shamt;
                word[FUNCT_LSB +: FUNCT_W] = funct;
            end
            FMT_I: begin
                word[OP_LSB  +: OP_W]  = opcode;
                word[RS_LSB  +: REG_W] = rs;
                word[RT_LSB  +: REG_W] = rt;
                word[IMM_LSB +: IMM_W] = imm16;
            end
            FMT_J: begin
                word[OP_LSB  +: OP_W]  = opcode;
                word[TGT_LSB +: TGT_W] = target;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles, packs them into 32-bit words and
// writes them to consecutive word addresses of an instruction memory starting
// at BASE_ADDR. One word per two cycles at best (accept, then write).
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN adds a running XOR
// checksum output of all written words.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               restart address/count/err without reset
//   in_valid/in_ready   bundle handshake
//   fmt..target         bundle fields
//   mem_we/addr/din     instruction-memory write port
//   count               words written so far
//   full                DEPTH words written, bundles ignored until clear
//   err                 sticky: an illegal fmt was accepted
//   checksum            (macro only) XOR of every written word
module instr_encoder
    import instr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [5:0]    opcode,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm16,
    input  logic [25:0]   target,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_din,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          err
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]   checksum
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    enc_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [31:0]   word_q, word_d;
    // Last word/address actually written; outputs fall back to these while
    // mem_we is low so the memory port holds steady.
    logic [31:0]   last_addr_q, last_addr_d;
    logic [31:0]   last_din_q, last_din_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic [31:0]   pack_word;
    logic          pack_legal;
    logic [31:0]   wr_addr;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    instr_field_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm16  (imm16),
        .target (target),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    // Address arithmetic is plain 32-bit, so it wraps past 0xFFFF_FFFC.
    assign wr_addr  = BASE_ADDR + (32'(count_q) << 2);
    assign cnt_inc  = count_q + 1'b1;

    assign in_ready = rst_n & ~clear & (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;

    // Reset or clear arriving in the WRITE cycle kills the write immediately.
    assign mem_we   = rst_n & ~clear & (state_q == ST_WRITE);
    assign mem_addr = mem_we ? wr_addr : last_addr_q;
    assign mem_din  = mem_we ? word_q  : last_din_q;
    assign count    = count_q;
    assign full     = (state_q == ST_FULL);
    assign err      = err_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    assign checksum = csum_q;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        word_d      = word_q;
        last_addr_d = last_addr_q;
        last_din_d  = last_din_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            err_d   = 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (pack_legal) begin
                            word_d  = pack_word;
                            state_d = ST_WRITE;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    count_d     = cnt_inc;
                    last_addr_d = wr_addr;
                    last_din_d  = word_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    csum_d      = csum_q ^ word_q;
`endif
                    state_d     = (cnt_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
                end
                ST_FULL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            word_q      <= '0;
            last_addr_q <= BASE_ADDR;
            last_din_q  <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            word_q      <= word_d;
            last_addr_q <= last_addr_d;
            last_din_q  <= last_din_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
